axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have parameter ID_M0, default 4'd0, meaning the AXI ar_id tagged on requester-0 (instruction refill) bursts.
REQ-002 The block SHALL have parameter ID_M1, default 4'd1, meaning the AXI ar_id tagged on requester-1 (data refill/uncached) bursts.
REQ-003 The block SHALL have port clk, input, 1, the only clock.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports m0_ar_valid/m1_ar_valid, input, 1 each, the read request from each requester.
REQ-006 The block SHALL have ports m0_ar_ready/m1_ar_ready, output, 1 each, the request-accepted strobe.
REQ-007 The block SHALL have ports mX_ar_addr in 32, mX_ar_len in 4, mX_ar_size in 3, the burst address, beats-1 and beat size.
REQ-008 The block SHALL have ports mX_r_valid out 1, mX_r_ready in 1, mX_r_data out 32, mX_r_resp out 2, mX_r_last out 1, the routed read data.
REQ-009 The block SHALL have downstream ports ar_valid/ar_id[3:0]/ar_addr[31:0]/ar_len[3:0]/ar_size[2:0]/ar_burst[1:0] out and ar_ready in, forming the AR channel.
REQ-010 The block SHALL have downstream ports r_valid/r_id[3:0]/r_data[31:0]/r_resp[1:0]/r_last in and r_ready out, forming the R channel.
REQ-011 The block SHALL have port id_err_o, output, 1, sticky flag set on an r_id mismatch.

Function
REQ-012 The FSM SHALL have three states: IDLE, ADDR and DATA, with exactly one burst outstanding at a time.
REQ-013 In IDLE, if any mX_ar_valid is high, the block SHALL grant one requester, assert its mX_ar_ready combinationally in that cycle, latch addr/len/size/id, and move to ADDR.
REQ-014 When both requesters are valid in IDLE, the grant SHALL go to the requester not granted last (round-robin); after reset, priority is m0.
REQ-015 In ADDR, the block SHALL drive ar_valid=1 with the latched fields and ar_burst=2'b01 (INCR), hold them stable until ar_ready, then move to DATA.
REQ-016 In DATA, the block SHALL route r_valid/r_data/r_resp/r_last to the granted requester only, drive r_ready from that requester's mX_r_ready, and hold all other mX_r_valid at 0.
REQ-017 When r_valid&r_ready&r_last occur in DATA, the block SHALL return to IDLE and update the last-granted register.
REQ-018 mX_ar_ready SHALL never be asserted outside IDLE, giving a minimum of 1 idle cycle between bursts.
REQ-019 A beat with r_valid high whose r_id differs from the latched id SHALL still be routed to the granted requester and SHALL set id_err_o, which stays set until reset.
REQ-020 r_ready SHALL be 0 in IDLE and ADDR, and r_valid SHALL be ignored in those states.
REQ-021 A len=0 burst SHALL complete on its single beat, which carries r_last.

Reset
REQ-022 Asserting rst_n low, including mid-burst, SHALL immediately force IDLE, ar_valid=0, r_ready=0, all mX_ar_ready/mX_r_valid=0, id_err_o=0, latched fields=0, and priority to m0.
REQ-023 After rst_n deasserts, the block SHALL accept a request in the first clock edge's IDLE cycle.

Structure
REQ-024 The state enum, the AR request struct {addr,len,size,id} and the INCR burst constant SHALL reside in the shared core package.
REQ-025 Grant selection SHALL be a sub-module rr_arb2 with two request bits, one last-grant bit, and a one-hot grant output.

Verification
REQ-026 Drive m0 alone, addr=0x1C000000, len=3, ar_ready on the first cycle: expect ar_id=0, 4 beats to m0, m1_r_valid=0 throughout, and IDLE after the 4th beat.
REQ-027 Drive m0 and m1 valid in the same IDLE cycle after reset: expect m0 granted first, m1 granted in the next IDLE, and m0 granted first again if both stay valid.
REQ-028 Hold ar_ready low 5 cycles in ADDR: expect ar_addr/ar_len/ar_id stable and no mX_ar_ready during the stall.
REQ-029 m1 len=0, addr=0xBFAF8000, with m1_r_ready low 3 cycles: expect r_ready=0 for those 3 cycles, then a single-beat completion.
REQ-030 Return a beat with r_id=2 during an m1 burst: expect data still routed to m1 and id_err_o=1 until reset.
REQ-031 Pull rst_n low on the 2nd of 4 beats: expect all outputs 0 asynchronously, then a new m1 request accepted right after release.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types for the two-requester AXI read arbiter.
//   state_e   : arbiter FSM states
//   ar_req_t  : latched AR request fields {addr, len, size, id}
//   BurstIncr : AXI INCR burst encoding driven on ar_burst
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
  } ar_req_t;

  localparam logic [1:0] BurstIncr = 2'b01;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for axi_rd_arbiter: two upstream AR/R requester ports (m0, m1)
// and one downstream AXI AR/R channel pair.
//   slave  : arbiter view (accepts requests, drives downstream AR, R routing)
//   master : environment view (requesters + downstream memory model)
interface axi_rd_arbiter_if;

  // Requester 0 (instruction refill)
  logic        m0_ar_valid;
  logic        m0_ar_ready;
  logic [31:0] m0_ar_addr;
  logic [3:0]  m0_ar_len;
  logic [2:0]  m0_ar_size;
  logic        m0_r_valid;
  logic        m0_r_ready;
  logic [31:0] m0_r_data;
  logic [1:0]  m0_r_resp;
  logic        m0_r_last;

  // Requester 1 (data refill / uncached)
  logic        m1_ar_valid;
  logic        m1_ar_ready;
  logic [31:0] m1_ar_addr;
  logic [3:0]  m1_ar_len;
  logic [2:0]  m1_ar_size;
  logic        m1_r_valid;
  logic        m1_r_ready;
  logic [31:0] m1_r_data;
  logic [1:0]  m1_r_resp;
  logic        m1_r_last;

  // Downstream AR channel
  logic        ar_valid;
  logic        ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;

  // Downstream R channel
  logic        r_valid;
  logic        r_ready;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;

  modport slave (
    input  m0_ar_valid, m0_ar_addr, m0_ar_len, m0_ar_size, m0_r_ready,
    output m0_ar_ready, m0_r_valid, m0_r_data, m0_r_resp, m0_r_last,
    input  m1_ar_valid, m1_ar_addr, m1_ar_len, m1_ar_size, m1_r_ready,
    output m1_ar_ready, m1_r_valid, m1_r_data, m1_r_resp, m1_r_last,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport master (
    output m0_ar_valid, m0_ar_addr, m0_ar_len, m0_ar_size, m0_r_ready,
    input  m0_ar_ready, m0_r_valid, m0_r_data, m0_r_resp, m0_r_last,
    output m1_ar_valid, m1_ar_addr, m1_ar_len, m1_ar_size, m1_r_ready,
    input  m1_ar_ready, m1_r_valid, m1_r_data, m1_r_resp, m1_r_last,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selector.
//   req      : request bits, [0] = m0, [1] = m1
//   last_gnt : requester granted most recently (0 = m0, 1 = m1)
//   gnt      : one-hot grant, all zero when nothing requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: favour whoever did not win last time.
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates two AXI read requesters onto one downstream AR/R channel with a
// single burst outstanding. IDLE grants (round-robin), ADDR presents the
// latched request until ar_ready, DATA routes R beats to the granted side
// until the r_last handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester and downstream signals (slave modport)
//   id_err_o   : sticky flag, set when a beat's r_id differs from the issued id
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [3:0] ID_M0 = 4'd0,
  parameter logic [3:0] ID_M1 = 4'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_rd_arbiter_if.slave    bus,
  output logic               id_err_o
);

  state_e     state_q, state_d;
  ar_req_t    req_q, req_d;
  logic       sel_q, sel_d;     // requester owning the current burst
  logic       last_q, last_d;   // requester that completed the last burst
  logic       id_err_q, id_err_d;
  logic [1:0] gnt;
  logic       r_ready_int;

  rr_arb2 u_rr_arb2 (
    .req      ({bus.m1_ar_valid, bus.m0_ar_valid}),
    .last_gnt (last_q),
    .gnt      (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      req_q    <= '0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;  // pretend m1 went last so m0 wins first contention
      id_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      id_err_q <= id_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    sel_d           = sel_q;
    last_d          = last_q;
    id_err_d        = id_err_q;
    r_ready_int     = 1'b0;

    bus.m0_ar_ready = 1'b0;
    bus.m1_ar_ready = 1'b0;
    bus.m0_r_valid  = 1'b0;
    bus.m0_r_data   = '0;
    bus.m0_r_resp   = '0;
    bus.m0_r_last   = 1'b0;
    bus.m1_r_valid  = 1'b0;
    bus.m1_r_data   = '0;
    bus.m1_r_resp   = '0;
    bus.m1_r_last   = 1'b0;
    bus.ar_valid    = 1'b0;
    bus.ar_burst    = 2'b00;
    bus.ar_addr     = req_q.addr;
    bus.ar_len      = req_q.len;
    bus.ar_size     = req_q.size;
    bus.ar_id       = req_q.id;

    unique case (state_q)
      StIdle: begin
        // rst_n gate keeps ar_ready low while reset is held.
        if (rst_n && (gnt != 2'b00)) begin
          bus.m0_ar_ready = gnt[0];
          bus.m1_ar_ready = gnt[1];
          sel_d           = gnt[1];
          if (gnt[1]) begin
            req_d.addr = bus.m1_ar_addr;
            req_d.len  = bus.m1_ar_len;
            req_d.size = bus.m1_ar_size;
            req_d.id   = ID_M1;
          end else begin
            req_d.addr = bus.m0_ar_addr;
            req_d.len  = bus.m0_ar_len;
            req_d.size = bus.m0_ar_size;
            req_d.id   = ID_M0;
          end
          state_d = StAddr;
        end
      end

      StAddr: begin
        bus.ar_valid = 1'b1;
        bus.ar_burst = BurstIncr;
        if (bus.ar_ready) begin
          state_d = StData;
        end
      end

      StData: begin
        r_ready_int = sel_q ? bus.m1_r_ready : bus.m0_r_ready;
        if (sel_q) begin
          bus.m1_r_valid = bus.r_valid;
          bus.m1_r_data  = bus.r_data;
          bus.m1_r_resp  = bus.r_resp;
          bus.m1_r_last  = bus.r_last;
        end else begin
          bus.m0_r_valid = bus.r_valid;
          bus.m0_r_data  = bus.r_data;
          bus.m0_r_resp  = bus.r_resp;
          bus.m0_r_last  = bus.r_last;
        end
        // Mismatched ids are still delivered; only the flag records them.
        if (bus.r_valid && (bus.r_id != req_q.id)) begin
          id_err_d = 1'b1;
        end
        if (bus.r_valid && r_ready_int && bus.r_last) begin
          state_d = StIdle;
          last_d  = sel_q;
        end
      end

      default: state_d = StIdle;
    endcase

    bus.r_ready = r_ready_int;
  end

  assign id_err_o = id_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_err;
  int   checks = 0;
  int   errors = 0;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter #(
    .ID_M0 (4'd0),
    .ID_M1 (4'd1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .id_err_o (id_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.m0_ar_valid = 1'b0; bus.m0_ar_addr = '0; bus.m0_ar_len = '0; bus.m0_ar_size = '0;
    bus.m0_r_ready  = 1'b0;
    bus.m1_ar_valid = 1'b0; bus.m1_ar_addr = '0; bus.m1_ar_len = '0; bus.m1_ar_size = '0;
    bus.m1_r_ready  = 1'b0;
    bus.ar_ready    = 1'b0;
    bus.r_valid     = 1'b0; bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0;
    bus.r_last      = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    bus.m0_ar_valid = 1'b1;
    bus.r_valid     = 1'b1;
    #1;
    checks++; if (bus.m0_ar_ready !== 1'b0) begin errors++;
      $display("FAIL rst_m0_ar_ready got %0h exp 0", bus.m0_ar_ready); end
    checks++; if (bus.ar_valid !== 1'b0) begin errors++;
      $display("FAIL rst_ar_valid got %0h exp 0", bus.ar_valid); end
    checks++; if (bus.r_ready !== 1'b0) begin errors++;
      $display("FAIL rst_r_ready got %0h exp 0", bus.r_ready); end
    checks++; if (id_err !== 1'b0) begin errors++;
      $display("FAIL rst_id_err got %0h exp 0", id_err); end
    checks++; if (bus.ar_addr !== 32'h0) begin errors++;
      $display("FAIL rst_ar_addr got %h exp 00000000", bus.ar_addr); end
    checks++; if (bus.m0_r_valid !== 1'b0) begin errors++;
      $display("FAIL rst_m0_r_valid got %0h exp 0", bus.m0_r_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single_m0();
    reset_dut();
    @(negedge clk);
    bus.m0_ar_valid = 1'b1; bus.m0_ar_addr = 32'h1C00_0000; bus.m0_ar_len = 4'd3;
    bus.m0_ar_size  = 3'd2;
    #1;
    checks++; if (bus.m0_ar_ready !== 1'b1) begin errors++;
      $display("FAIL m0_grant got %0h exp 1", bus.m0_ar_ready); end
    checks++; if (bus.m1_ar_ready !== 1'b0) begin errors++;
      $display("FAIL m0_grant_m1_ready got %0h exp 0", bus.m1_ar_ready); end
    @(negedge clk);
    bus.m0_ar_valid = 1'b0; bus.ar_ready = 1'b1;
    #1;
    checks++; if (bus.ar_valid !== 1'b1) begin errors++;
      $display("FAIL m0_ar_valid got %0h exp 1", bus.ar_valid); end
    checks++; if (bus.ar_id !== 4'd0) begin errors++;
      $display("FAIL m0_ar_id got %0h exp 0", bus.ar_id); end
    checks++; if (bus.ar_addr !== 32'h1C00_0000) begin errors++;
      $display("FAIL m0_ar_addr got %h exp 1c000000", bus.ar_addr); end
    checks++; if (bus.ar_len !== 4'd3) begin errors++;
      $display("FAIL m0_ar_len got %0d exp 3", bus.ar_len); end
    checks++; if (bus.ar_size !== 3'd2) begin errors++;
      $display("FAIL m0_ar_size got %0d exp 2", bus.ar_size); end
    checks++; if (bus.ar_burst !== 2'b01) begin errors++;
      $display("FAIL m0_ar_burst got %0h exp 1", bus.ar_burst); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_id = 4'd0;
      bus.r_data = 32'hA000_0000 + 32'(i); bus.r_resp = 2'(i); bus.r_last = (i == 3);
      bus.m0_r_ready = 1'b1;
      #1;
      checks++; if (bus.m0_r_valid !== 1'b1) begin errors++;
        $display("FAIL m0_beat%0d_valid got %0h exp 1", i, bus.m0_r_valid); end
      checks++; if (bus.m0_r_data !== 32'hA000_0000 + 32'(i)) begin errors++;
        $display("FAIL m0_beat%0d_data got %h exp %h", i, bus.m0_r_data,
                 32'hA000_0000 + 32'(i)); end
      checks++; if (bus.m0_r_resp !== 2'(i)) begin errors++;
        $display("FAIL m0_beat%0d_resp got %0h exp %0h", i, bus.m0_r_resp, 2'(i)); end
      checks++; if (bus.m0_r_last !== (i == 3)) begin errors++;
        $display("FAIL m0_beat%0d_last got %0h exp %0h", i, bus.m0_r_last, (i == 3)); end
      checks++; if (bus.m1_r_valid !== 1'b0) begin errors++;
        $display("FAIL m0_beat%0d_m1_valid got %0h exp 0", i, bus.m1_r_valid); end
      checks++; if (bus.r_ready !== 1'b1) begin errors++;
        $display("FAIL m0_beat%0d_r_ready got %0h exp 1", i, bus.r_ready); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.r_ready !== 1'b0) begin errors++;
      $display("FAIL m0_done_r_ready got %0h exp 0", bus.r_ready); end
    checks++; if (bus.m0_r_valid !== 1'b0) begin errors++;
      $display("FAIL m0_done_m0_valid got %0h exp 0", bus.m0_r_valid); end
    checks++; if (bus.ar_valid !== 1'b0) begin errors++;
      $display("FAIL m0_done_ar_valid got %0h exp 0", bus.ar_valid); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    reset_dut();
    @(negedge clk);
    bus.m0_ar_valid = 1'b1; bus.m0_ar_addr = 32'h0000_0100;
    bus.m1_ar_valid = 1'b1; bus.m1_ar_addr = 32'h0000_0200;
    bus.m0_r_ready  = 1'b1; bus.m1_r_ready = 1'b1;
    #1;
    checks++; if (bus.m0_ar_ready !== 1'b1 || bus.m1_ar_ready !== 1'b0) begin errors++;
      $display("FAIL rr_first got m0=%0h m1=%0h exp m0=1 m1=0",
               bus.m0_ar_ready, bus.m1_ar_ready); end
    @(negedge clk);
    bus.ar_ready = 1'b1;
    #1;
    checks++; if (bus.ar_id !== 4'd0 || bus.ar_addr !== 32'h100) begin errors++;
      $display("FAIL rr_first_ar got id=%0h addr=%h exp id=0 addr=00000100",
               bus.ar_id, bus.ar_addr); end
    checks++; if (bus.m1_ar_ready !== 1'b0) begin errors++;
      $display("FAIL rr_addr_m1_ready got %0h exp 0", bus.m1_ar_ready); end
    @(negedge clk);
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_id = 4'd0; bus.r_last = 1'b1;
    #1;
    checks++; if (bus.m0_r_valid !== 1'b1 || bus.m1_r_valid !== 1'b0) begin errors++;
      $display("FAIL rr_first_data got m0=%0h m1=%0h exp m0=1 m1=0",
               bus.m0_r_valid, bus.m1_r_valid); end
    @(negedge clk);
    bus.r_valid = 1'b0;
    #1;
    checks++; if (bus.m1_ar_ready !== 1'b1 || bus.m0_ar_ready !== 1'b0) begin errors++;
      $display("FAIL rr_second got m0=%0h m1=%0h exp m0=0 m1=1",
               bus.m0_ar_ready, bus.m1_ar_ready); end
    @(negedge clk);
    bus.ar_ready = 1'b1;
    #1;
    checks++; if (bus.ar_id !== 4'd1 || bus.ar_addr !== 32'h200) begin errors++;
      $display("FAIL rr_second_ar got id=%0h addr=%h exp id=1 addr=00000200",
               bus.ar_id, bus.ar_addr); end
    @(negedge clk);
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_id = 4'd1; bus.r_last = 1'b1;
    #1;
    checks++; if (bus.m1_r_valid !== 1'b1 || bus.m0_r_valid !== 1'b0) begin errors++;
      $display("FAIL rr_second_data got m0=%0h m1=%0h exp m0=0 m1=1",
               bus.m0_r_valid, bus.m1_r_valid); end
    @(negedge clk);
    bus.r_valid = 1'b0;
    #1;
    checks++; if (bus.m0_ar_ready !== 1'b1 || bus.m1_ar_ready !== 1'b0) begin errors++;
      $display("FAIL rr_third got m0=%0h m1=%0h exp m0=1 m1=0",
               bus.m0_ar_ready, bus.m1_ar_ready); end
    checks++; if (id_err !== 1'b0) begin errors++;
      $display("FAIL rr_id_err got %0h exp 0", id_err); end
    clear_inputs();
  endtask

  task automatic test_addr_stall();
    reset_dut();
    @(negedge clk);
    bus.m1_ar_valid = 1'b1; bus.m1_ar_addr = 32'h8000_1000; bus.m1_ar_len = 4'd2;
    bus.m1_ar_size  = 3'd2;
    #1;
    checks++; if (bus.m1_ar_ready !== 1'b1) begin errors++;
      $display("FAIL stall_grant got %0h exp 1", bus.m1_ar_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.ar_ready = 1'b0; bus.m1_ar_addr = 32'hFFFF_0000; bus.m1_ar_len = 4'hF;
      bus.m0_ar_valid = 1'b1;
      #1;
      checks++; if (bus.ar_valid !== 1'b1 || bus.ar_addr !== 32'h8000_1000 ||
                    bus.ar_len !== 4'd2 || bus.ar_id !== 4'd1) begin errors++;
        $display("FAIL stall%0d_ar got v=%0h addr=%h len=%0d id=%0h exp v=1 addr=80001000 len=2 id=1",
                 i, bus.ar_valid, bus.ar_addr, bus.ar_len, bus.ar_id); end
      checks++; if (bus.m0_ar_ready !== 1'b0 || bus.m1_ar_ready !== 1'b0) begin errors++;
        $display("FAIL stall%0d_ar_ready got m0=%0h m1=%0h exp 0 0",
                 i, bus.m0_ar_ready, bus.m1_ar_ready); end
    end
    @(negedge clk);
    bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0;
    #1;
    checks++; if (bus.ar_valid !== 1'b0 || bus.m0_ar_ready !== 1'b0) begin errors++;
      $display("FAIL stall_data got ar_valid=%0h m0_ar_ready=%0h exp 0 0",
               bus.ar_valid, bus.m0_ar_ready); end
    clear_inputs();
  endtask

  task automatic test_len0_backpressure();
    reset_dut();
    @(negedge clk);
    bus.m1_ar_valid = 1'b1; bus.m1_ar_addr = 32'hBFAF_8000; bus.m1_ar_len = 4'd0;
    #1;
    checks++; if (bus.m1_ar_ready !== 1'b1) begin errors++;
      $display("FAIL len0_grant got %0h exp 1", bus.m1_ar_ready); end
    @(negedge clk);
    bus.m1_ar_valid = 1'b0; bus.ar_ready = 1'b1;
    bus.r_valid = 1'b1; bus.r_last = 1'b1; bus.r_id = 4'd1; bus.m1_r_ready = 1'b1;
    #1;
    checks++; if (bus.ar_addr !== 32'hBFAF_8000 || bus.ar_len !== 4'd0) begin errors++;
      $display("FAIL len0_ar got addr=%h len=%0d exp addr=bfaf8000 len=0",
               bus.ar_addr, bus.ar_len); end
    checks++; if (bus.r_ready !== 1'b0 || bus.m1_r_valid !== 1'b0) begin errors++;
      $display("FAIL len0_addr_r got r_ready=%0h m1_r_valid=%0h exp 0 0",
               bus.r_ready, bus.m1_r_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ar_ready = 1'b0; bus.r_data = 32'h5555_0000; bus.m1_r_ready = 1'b0;
      #1;
      checks++; if (bus.r_ready !== 1'b0 || bus.m1_r_valid !== 1'b1) begin errors++;
        $display("FAIL len0_hold%0d got r_ready=%0h m1_r_valid=%0h exp 0 1",
                 i, bus.r_ready, bus.m1_r_valid); end
    end
    @(negedge clk);
    bus.m1_r_ready = 1'b1;
    #1;
    checks++; if (bus.r_ready !== 1'b1 || bus.m1_r_last !== 1'b1 ||
                  bus.m1_r_data !== 32'h5555_0000) begin errors++;
      $display("FAIL len0_beat got r_ready=%0h last=%0h data=%h exp 1 1 55550000",
               bus.r_ready, bus.m1_r_last, bus.m1_r_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.r_ready !== 1'b0 || bus.m1_r_valid !== 1'b0) begin errors++;
      $display("FAIL len0_done got r_ready=%0h m1_r_valid=%0h exp 0 0",
               bus.r_ready, bus.m1_r_valid); end
    clear_inputs();
  endtask

  task automatic test_id_err();
    reset_dut();
    @(negedge clk);
    bus.m1_ar_valid = 1'b1; bus.m1_ar_addr = 32'h0000_4000; bus.m1_ar_len = 4'd1;
    @(negedge clk);
    bus.m1_ar_valid = 1'b0; bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_id = 4'd2; bus.r_data = 32'hDEAD_BEEF;
    bus.r_last = 1'b0; bus.m1_r_ready = 1'b1;
    #1;
    checks++; if (bus.m1_r_valid !== 1'b1 || bus.m1_r_data !== 32'hDEAD_BEEF ||
                  bus.m0_r_valid !== 1'b0) begin errors++;
      $display("FAIL iderr_route got m1_v=%0h data=%h m0_v=%0h exp 1 deadbeef 0",
               bus.m1_r_valid, bus.m1_r_data, bus.m0_r_valid); end
    @(negedge clk);
    bus.r_id = 4'd1; bus.r_last = 1'b1;
    #1;
    checks++; if (id_err !== 1'b1) begin errors++;
      $display("FAIL iderr_set got %0h exp 1", id_err); end
    @(negedge clk);
    bus.r_valid = 1'b0;
    #1;
    checks++; if (id_err !== 1'b1) begin errors++;
      $display("FAIL iderr_sticky got %0h exp 1", id_err); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (id_err !== 1'b0) begin errors++;
      $display("FAIL iderr_reset got %0h exp 0", id_err); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    @(negedge clk);
    bus.m0_ar_valid = 1'b1; bus.m0_ar_addr = 32'h0000_2000; bus.m0_ar_len = 4'd3;
    @(negedge clk);
    bus.m0_ar_valid = 1'b0; bus.ar_ready = 1'b1;
    @(negedge clk);
    bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_id = 4'd0; bus.r_data = 32'h1111_0000;
    bus.m0_r_ready = 1'b1;
    #1;
    checks++; if (bus.m0_r_valid !== 1'b1) begin errors++;
      $display("FAIL mid_beat1 got %0h exp 1", bus.m0_r_valid); end
    @(negedge clk);
    bus.r_data = 32'h1111_0001;
    bus.m1_ar_valid = 1'b1; bus.m1_ar_addr = 32'h0000_3000; bus.m1_ar_len = 4'd0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.m0_r_valid !== 1'b0 || bus.r_ready !== 1'b0 ||
                  bus.ar_valid !== 1'b0) begin errors++;
      $display("FAIL mid_rst_data got m0_v=%0h r_ready=%0h ar_valid=%0h exp 0 0 0",
               bus.m0_r_valid, bus.r_ready, bus.ar_valid); end
    checks++; if (bus.m0_ar_ready !== 1'b0 || bus.m1_ar_ready !== 1'b0) begin errors++;
      $display("FAIL mid_rst_ar_ready got m0=%0h m1=%0h exp 0 0",
               bus.m0_ar_ready, bus.m1_ar_ready); end
    checks++; if (bus.ar_addr !== 32'h0 || bus.ar_len !== 4'd0) begin errors++;
      $display("FAIL mid_rst_fields got addr=%h len=%0d exp 00000000 0",
               bus.ar_addr, bus.ar_len); end
    #1;
    rst_n = 1'b1; bus.r_valid = 1'b0;
    #1;
    checks++; if (bus.m1_ar_ready !== 1'b1) begin errors++;
      $display("FAIL mid_release_grant got %0h exp 1", bus.m1_ar_ready); end
    @(negedge clk);
    bus.m1_ar_valid = 1'b0; bus.ar_ready = 1'b1;
    #1;
    checks++; if (bus.ar_valid !== 1'b1 || bus.ar_id !== 4'd1 ||
                  bus.ar_addr !== 32'h3000) begin errors++;
      $display("FAIL mid_release_ar got v=%0h id=%0h addr=%h exp 1 1 00003000",
               bus.ar_valid, bus.ar_id, bus.ar_addr); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_m0();
    test_round_robin();
    test_addr_stall();
    test_len0_backpressure();
    test_id_err();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
